// File: rtl/wb_int_arbiter_if.sv
// Bus bundle between the integer FUs, the writeback arbiter and the PRF/ROB.
// Supplies defaults for PRF_INT_WAYS, PRF_INT_INDEX_SIZE and ROB_INDEX_SIZE when they are undefined.
`ifndef PRF_INT_WAYS
`define PRF_INT_WAYS 4
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif
`ifndef ROB_INDEX_SIZE
`define ROB_INDEX_SIZE 6
`endif

interface wb_int_arbiter_if #(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned WAYS    = `PRF_INT_WAYS,
    parameter int unsigned IDX_W   = `PRF_INT_INDEX_SIZE,
    parameter int unsigned ROB_W   = `ROB_INDEX_SIZE
);
    logic [NUM_SRC-1:0]                src_valid;
    logic [NUM_SRC-1:0][IDX_W-1:0]     src_index;
    logic [NUM_SRC-1:0][31:0]          src_data;
    logic [NUM_SRC-1:0][ROB_W-1:0]     src_rob;
    logic [NUM_SRC-1:0]                src_ready;

    logic [WAYS-1:0]                   rd_en;
    logic [WAYS-1:0][IDX_W-1:0]        rd_index;
    logic [WAYS-1:0][31:0]             rd_data;
    logic [WAYS-1:0]                   cmt_valid;
    logic [WAYS-1:0][ROB_W-1:0]        cmt_rob;

    // Arbiter side.
    modport slave (
        input  src_valid, src_index, src_data, src_rob,
        output src_ready, rd_en, rd_index, rd_data, cmt_valid, cmt_rob
    );

    // Producer / consumer side.
    modport master (
        output src_valid, src_index, src_data, src_rob,
        input  src_ready, rd_en, rd_index, rd_data, cmt_valid, cmt_rob
    );
endinterface

// File: rtl/wb_int_arbiter.sv
// Integer writeback arbiter: rotating-priority grant of up to WAYS results into PRF/ROB lanes.
// Optional macro WB_INT_ZERO_DROP_EN treats physical register 0 as hardwired zero.
`ifndef PRF_INT_WAYS
`define PRF_INT_WAYS 4
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif
`ifndef ROB_INDEX_SIZE
`define ROB_INDEX_SIZE 6
`endif

module wb_int_arbiter #(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned WAYS    = `PRF_INT_WAYS,
    parameter int unsigned IDX_W   = `PRF_INT_INDEX_SIZE,
    parameter int unsigned ROB_W   = `ROB_INDEX_SIZE
) (
    input logic             clock,
    input logic             reset,
    input logic             flush,
    wb_int_arbiter_if.slave bus
);
    localparam int unsigned PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned LANE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [WAYS-1:0]               rd_en_q, rd_en_d;
    logic [WAYS-1:0][IDX_W-1:0]    rd_index_q, rd_index_d;
    logic [WAYS-1:0][31:0]         rd_data_q, rd_data_d;
    logic [WAYS-1:0]               cmt_valid_q, cmt_valid_d;
    logic [WAYS-1:0][ROB_W-1:0]    cmt_rob_q, cmt_rob_d;
    logic [NUM_SRC-1:0]            ready;
    logic [NUM_SRC-1:0]            zero_idx;

`ifdef WB_INT_ZERO_DROP_EN
    always_comb begin
        zero_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            zero_idx[k] = bus.src_valid[k] && (bus.src_index[k] == '0);
        end
    end
`else
    assign zero_idx = '0;
`endif

    always_comb begin
        int unsigned      cnt;
        logic [PTR_W-1:0] s;
        logic [LANE_W-1:0] lane;
        cnt         = 0;
        s           = '0;
        lane        = '0;
        ready       = '0;
        rr_ptr_d    = rr_ptr_q;
        rd_en_d     = '0;
        rd_index_d  = '0;
        rd_data_d   = '0;
        cmt_valid_d = '0;
        cmt_rob_d   = '0;
        if (reset && !flush) begin
            // Nonzero-destination results claim lanes first, in circular order from rr_ptr.
            for (int i = 0; i < NUM_SRC; i++) begin
                s = PTR_W'((int'(rr_ptr_q) + i) % NUM_SRC);
                if (bus.src_valid[s] && !zero_idx[s] && cnt < WAYS) begin
                    lane              = LANE_W'(cnt);
                    ready[s]          = 1'b1;
                    rd_en_d[lane]     = 1'b1;
                    rd_index_d[lane]  = bus.src_index[s];
                    rd_data_d[lane]   = bus.src_data[s];
                    cmt_valid_d[lane] = 1'b1;
                    cmt_rob_d[lane]   = bus.src_rob[s];
                    rr_ptr_d          = PTR_W'((int'(s) + 1) % NUM_SRC);
                    cnt++;
                end
            end
            // Writes to r0 are always absorbed; their completion rides a spare lane if any.
            for (int i = 0; i < NUM_SRC; i++) begin
                s = PTR_W'((int'(rr_ptr_q) + i) % NUM_SRC);
                if (zero_idx[s]) begin
                    ready[s] = 1'b1;
                    if (cnt < WAYS) begin
                        lane              = LANE_W'(cnt);
                        cmt_valid_d[lane] = 1'b1;
                        cmt_rob_d[lane]   = bus.src_rob[s];
                        cnt++;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            rd_en_q     <= '0;
            rd_index_q  <= '0;
            rd_data_q   <= '0;
            cmt_valid_q <= '0;
            cmt_rob_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rd_en_q     <= rd_en_d;
            rd_index_q  <= rd_index_d;
            rd_data_q   <= rd_data_d;
            cmt_valid_q <= cmt_valid_d;
            cmt_rob_q   <= cmt_rob_d;
        end
    end

    assign bus.src_ready = ready;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_index  = rd_index_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.cmt_valid = cmt_valid_q;
    assign bus.cmt_rob   = cmt_rob_q;

`ifndef SYNTHESIS
    // Two lanes writing one physical register in a cycle means a rename bug upstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                for (int j = i + 1; j < WAYS; j++) begin
                    assert (!(rd_en_q[i] && rd_en_q[j] && rd_index_q[i] == rd_index_q[j]))
                    else $error("duplicate rd_index %0d on lanes %0d and %0d", rd_index_q[i], i, j);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_int_arbiter.sv
// Directed bench for wb_int_arbiter: grant order, rotation, hold, flush and reset behaviour.
module tb_wb_int_arbiter;
    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned WAYS    = 4;
    localparam int unsigned IDX_W   = 7;
    localparam int unsigned ROB_W   = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    wb_int_arbiter_if #(.NUM_SRC(NUM_SRC), .WAYS(WAYS), .IDX_W(IDX_W), .ROB_W(ROB_W)) bus ();

    wb_int_arbiter #(.NUM_SRC(NUM_SRC), .WAYS(WAYS), .IDX_W(IDX_W), .ROB_W(ROB_W)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int s, input int idx, input int data, input int rob);
        bus.src_valid[s] = 1'b1;
        bus.src_index[s] = IDX_W'(idx);
        bus.src_data[s]  = 32'(data);
        bus.src_rob[s]   = ROB_W'(rob);
    endtask

    task automatic drop_src(input int s);
        bus.src_valid[s] = 1'b0;
        bus.src_index[s] = '0;
        bus.src_data[s]  = '0;
        bus.src_rob[s]   = '0;
    endtask

    task automatic clear_all();
        for (int s = 0; s < NUM_SRC; s++) drop_src(s);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset held with every source valid.
        clear_all();
        for (int s = 0; s < NUM_SRC; s++) set_src(s, s + 1, 'h50 + s, s);
        #2;
        check("rst_ready", bus.src_ready, 0);
        tick();
        tick();
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_cmt_valid", bus.cmt_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);

        // Two sources, both granted in order.
        reset = 1'b1;
        clear_all();
        set_src(0, 5, 'hA, 1);
        set_src(1, 9, 'hB, 2);
        #1;
        check("two_ready", bus.src_ready, 6'b000011);
        tick();
        check("two_rd_en", bus.rd_en, 4'b0011);
        check("two_idx0", bus.rd_index[0], 5);
        check("two_idx1", bus.rd_index[1], 9);
        check("two_data0", bus.rd_data[0], 'hA);
        check("two_data1", bus.rd_data[1], 'hB);
        check("two_cmt_valid", bus.cmt_valid, 4'b0011);
        check("two_cmt_rob1", bus.cmt_rob[1], 2);
        check("two_unused_data", bus.rd_data[2], 0);

        // Reset for one cycle while outputs are active; rr_ptr was 2.
        reset = 1'b0;
        clear_all();
        set_src(0, 11, 'h100, 3);
        set_src(3, 12, 'h200, 4);
        #1;
        check("mid_rst_ready", bus.src_ready, 0);
        tick();
        check("mid_rst_rd_en", bus.rd_en, 0);
        check("mid_rst_cmt_valid", bus.cmt_valid, 0);
        check("mid_rst_rd_data", bus.rd_data, 0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", bus.src_ready, 6'b001001);
        tick();
        check("post_rst_rd_en", bus.rd_en, 4'b0011);
        check("post_rst_idx0", bus.rd_index[0], 11);
        check("post_rst_idx1", bus.rd_index[1], 12);
        check("post_rst_data1", bus.rd_data[1], 'h200);
        check("post_rst_rob0", bus.cmt_rob[0], 3);

        // Source 5 alone: lands on lane 0, rr_ptr wraps to 0.
        clear_all();
        set_src(5, 13, 'h300, 5);
        #1;
        check("s5_ready", bus.src_ready, 6'b100000);
        tick();
        check("s5_rd_en", bus.rd_en, 4'b0001);
        check("s5_idx0", bus.rd_index[0], 13);
        check("s5_rob0", bus.cmt_rob[0], 5);

        // All six valid from rr_ptr 0.
        clear_all();
        for (int s = 0; s < NUM_SRC; s++) set_src(s, 20 + s, 'h1000 + s, 10 + s);
        #1;
        check("all1_ready", bus.src_ready, 6'b001111);
        tick();
        check("all1_rd_en", bus.rd_en, 4'b1111);
        for (int l = 0; l < 4; l++) check("all1_idx", bus.rd_index[l], 20 + l);
        check("all1_cmt_valid", bus.cmt_valid, 4'b1111);

        // Granted sources 0..3 present new results; 4 and 5 hold theirs.
        for (int s = 0; s < 4; s++) set_src(s, 30 + s, 'h2000 + s, 20 + s);
        #1;
        check("all2_ready", bus.src_ready, 6'b110011);
        tick();
        check("all2_idx0", bus.rd_index[0], 24);
        check("all2_idx1", bus.rd_index[1], 25);
        check("all2_idx2", bus.rd_index[2], 30);
        check("all2_idx3", bus.rd_index[3], 31);
        check("all2_data0", bus.rd_data[0], 'h1004);
        check("all2_rob3", bus.cmt_rob[3], 21);

        // Sources 2,3 waited one cycle with ready low; they are served now.
        set_src(4, 34, 'h3004, 24);
        set_src(5, 35, 'h3005, 25);
        set_src(0, 40, 'h4000, 30);
        set_src(1, 41, 'h4001, 31);
        #1;
        check("all3_ready", bus.src_ready, 6'b111100);
        tick();
        check("all3_idx0", bus.rd_index[0], 32);
        check("all3_idx1", bus.rd_index[1], 33);
        check("all3_data1", bus.rd_data[1], 'h2003);
        check("all3_idx3", bus.rd_index[3], 35);

        // Flush with three sources valid; registered results still drive.
        flush = 1'b1;
        drop_src(2);
        drop_src(4);
        drop_src(5);
        set_src(3, 43, 'h4003, 33);
        #1;
        check("flush_ready", bus.src_ready, 0);
        check("flush_keep_rd_en", bus.rd_en, 4'b1111);
        tick();
        check("flush_rd_en", bus.rd_en, 0);
        check("flush_cmt_valid", bus.cmt_valid, 0);

        // Resume from unchanged rr_ptr 0 with an extra source 5.
        flush = 1'b0;
        set_src(5, 45, 'h4005, 35);
        #1;
        check("resume_ready", bus.src_ready, 6'b101011);
        tick();
        check("resume_rd_en", bus.rd_en, 4'b1111);
        check("resume_idx0", bus.rd_index[0], 40);
        check("resume_idx1", bus.rd_index[1], 41);
        check("resume_idx2", bus.rd_index[2], 43);
        check("resume_idx3", bus.rd_index[3], 45);

        // Idle: outputs last exactly one cycle.
        clear_all();
        #1;
        check("idle_ready", bus.src_ready, 0);
        tick();
        check("idle_rd_en", bus.rd_en, 0);
        check("idle_cmt_valid", bus.cmt_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
